// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-port owner: merges the never-stalling WB stage with a
// FIFO of long-latency (mul/div) results that drain into idle WB slots.
// Also reports pending queued writes to the hazard unit.
module regfile_writeback_arbiter #(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned ADDR_SIZE = 5,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_we,
  input  logic [ADDR_SIZE-1:0]   wb_addr,
  input  logic [REG_WIDTH-1:0]   wb_data,
  input  logic                   sec_valid,
  output logic                   sec_ready,
  input  logic [ADDR_SIZE-1:0]   sec_addr,
  input  logic [REG_WIDTH-1:0]   sec_data,
  output logic                   RegWrite,
  output logic [ADDR_SIZE-1:0]   write_register,
  output logic [REG_WIDTH-1:0]   write_data,
  input  logic [ADDR_SIZE-1:0]   query_addr,
  output logic                   query_pending,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] addr;
    logic [REG_WIDTH-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic   full;
  logic   empty;
  logic   wb_active;
  logic   push;
  logic   pop;
  entry_t head;

  // WB with a zero destination is treated as an idle slot.
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign wb_active = wb_we && (wb_addr != '0);
  assign sec_ready = !rst && !full;
  // Zero-destination results complete the handshake but are dropped.
  assign push      = sec_valid && sec_ready && (sec_addr != '0);
  assign pop       = !rst && !wb_active && !empty;
  assign head      = mem[rd_ptr];
  assign fifo_count = count;

  // FIFO storage; payload needs no reset since valid bits qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= entry_t'({sec_addr, sec_data});
    end
  end

  // FIFO control: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Write-port select: WB first, otherwise the FIFO head, otherwise idle.
  always_comb begin
    RegWrite       = 1'b0;
    write_register = '0;
    write_data     = '0;
    if (!rst) begin
      if (wb_active) begin
        RegWrite       = 1'b1;
        write_register = wb_addr;
        write_data     = wb_data;
      end else if (!empty) begin
        RegWrite       = 1'b1;
        write_register = head.addr;
        write_data     = head.data;
      end
    end
  end

  // Hazard lookup across all queued entries, including the one draining now.
  always_comb begin
    query_pending = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && (mem[i].addr == query_addr)) begin
        query_pending = 1'b1;
      end
    end
    if (query_addr == '0) begin
      query_pending = 1'b0;
    end
  end

endmodule
